// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   F3_*       : RISC-V load/store size/sign encodings
//   mem_state_e: responder FSM encoding
//   CNT_W      : latency counter width (supports LAT 1..15)
package rv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;
endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic for one access.
//   addr_lo : byte offset within the word
//   funct3  : size/sign field
//   we      : 1 = store
//   wdata   : store data, LSB-aligned
//   rword   : current contents of the addressed word
//   be      : byte enables for the write (0 on error or load)
//   wword   : rword with enabled bytes replaced by store data
//   ldata   : extended load result (0 for stores and errors)
//   err     : misaligned access or illegal funct3
module dmem_lane
  import rv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        err
);
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] wrep;

  assign bsel = rword[{addr_lo, 3'b000} +: 8];
  assign hsel = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Replicate store data across all lanes so the byte enables alone pick the target.
  always_comb begin
    wrep = wdata;
    case (funct3[1:0])
      2'b00:   wrep = {4{wdata[7:0]}};
      2'b01:   wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    ldata = 32'h0;
    err   = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << addr_lo;
        ldata = {{24{bsel[7]}}, bsel};
      end
      F3_BU: begin
        err   = we;
        ldata = {24'h0, bsel};
      end
      F3_H: begin
        err   = addr_lo[0];
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        ldata = {{16{hsel[15]}}, hsel};
      end
      F3_HU: begin
        err   = addr_lo[0] | we;
        ldata = {16'h0, hsel};
      end
      F3_W: begin
        err   = |addr_lo;
        be    = 4'b1111;
        ldata = rword;
      end
      default: err = 1'b1;
    endcase
    if (err || !we) be = 4'b0000;
    if (err || we) ldata = 32'h0;
  end

  always_comb begin
    wword = rword;
    for (int i = 0; i < 4; i++)
      if (be[i]) wword[8*i +: 8] = wrep[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for a core load/store port.
//   clk, reset_n             : clock, async active-low reset
//   req_valid/req_ready      : request handshake (we, addr, funct3, wdata)
//   rsp_valid/rsp_ready      : response handshake (rdata, err)
// One transaction in flight. The memory access (and store commit) happens on
// the edge that enters RESP; response registers then hold until taken.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int AW  = 8,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  mem_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic          cap_we;
  logic [AW+1:0] cap_addr;
  logic [2:0]    cap_f3;
  logic [31:0]   cap_wdata;

  logic          acc_we;
  logic [AW+1:0] acc_addr;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_wdata;
  logic [31:0]   rword, wword, ldata;
  logic [3:0]    be;
  logic          lane_err, enter_resp, mem_wr;

  logic [31:0] mem [2**AW];

  // Upper address bits are ignored by design (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = (state == MEM_IDLE);
  assign rsp_valid = (state == MEM_RESP);

  // With LAT=1 the access happens on the accept edge, before capture, so the
  // lane logic reads straight from the request port while idle.
  always_comb begin
    if (state == MEM_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr[AW+1:0];
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_f3    = cap_f3;
      acc_wdata = cap_wdata;
    end
  end

  assign rword = mem[acc_addr[AW+1:2]];

  dmem_lane u_lane (
    .addr_lo (acc_addr[1:0]),
    .funct3  (acc_f3),
    .we      (acc_we),
    .wdata   (acc_wdata),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .ldata   (ldata),
    .err     (lane_err)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (req_valid) begin
          if (LAT == 1) begin
            state_nxt  = MEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = MEM_BUSY;
            cnt_nxt   = CNT_W'(LAT - 1);
          end
        end
      end
      MEM_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt  = MEM_RESP;
          cnt_nxt    = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      MEM_RESP: begin
        if (rsp_ready) state_nxt = MEM_IDLE;
      end
      default: begin
        state_nxt = MEM_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_f3    <= 3'b000;
      cap_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == MEM_IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr[AW+1:0];
        cap_f3    <= req_funct3;
        cap_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata <= ldata;
        rsp_err   <= lane_err;
      end
    end
  end

  // Memory is not reset; reset_n gates the write so an edge seen while reset
  // is held can never commit a store.
  assign mem_wr = enter_resp & acc_we & ~lane_err & reset_n;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[acc_addr[AW+1:2]] <= wword;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LAT=2, LAT=3, LAT=1) share request fields,
// each with its own req_valid.
module tb_dmem_responder;
  import rv_mem_pkg::*;

  logic        clk, reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready, rsp_valid, rsp_err;
  logic [2:0][31:0] rsp_rdata;
  logic        req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.AW(8), .LAT(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.AW(8), .LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  dmem_responder #(.AW(8), .LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on instance k and wait (bounded) for the response.
  task automatic issue(input int k, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, output int n);
    @(posedge clk); #1;
    chk("idle_rdy", {31'h0, req_ready[k]}, 32'h1);
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic txn(input string tag, input int k, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd, input int lat,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    issue(k, we, addr, f3, wd, n);
    chk({tag, ".lat"}, 32'(n), 32'(lat - 1));
    chk({tag, ".rdata"}, rsp_rdata[k], exp_rd);
    chk({tag, ".err"}, {31'h0, rsp_err[k]}, {31'h0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rdy_after"}, {30'h0, rsp_valid[k], req_ready[k]}, 32'h1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; req_valid = 3'b000; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_funct3 = 3'b000; req_wdata = 32'h0;
    #12;
    chk("rst.ready", {29'h0, req_ready}, 32'h7);
    chk("rst.valid", {29'h0, rsp_valid}, 32'h0);
    chk("rst.err",   {29'h0, rsp_err}, 32'h0);
    chk("rst.rdata", rsp_rdata[0], 32'h0);
    @(posedge clk); #3;
    reset_n = 1'b1;

    // Word store / load
    txn("sw10", 0, 1'b1, 32'h10, F3_W, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    txn("lw10", 0, 1'b0, 32'h10, F3_W, 32'h0, 2, 32'hDEADBEEF, 1'b0);

    // Sub-word stores and extension
    txn("sw20",  0, 1'b1, 32'h20, F3_W,  32'h0,        2, 32'h0, 1'b0);
    txn("sb21",  0, 1'b1, 32'h21, F3_B,  32'h12345680, 2, 32'h0, 1'b0);
    txn("lb21",  0, 1'b0, 32'h21, F3_B,  32'h0, 2, 32'hFFFFFF80, 1'b0);
    txn("lbu21", 0, 1'b0, 32'h21, F3_BU, 32'h0, 2, 32'h00000080, 1'b0);
    txn("sh22",  0, 1'b1, 32'h22, F3_H,  32'hABCD8001, 2, 32'h0, 1'b0);
    txn("lw20",  0, 1'b0, 32'h20, F3_W,  32'h0, 2, 32'h80018000, 1'b0);
    txn("lh22",  0, 1'b0, 32'h22, F3_H,  32'h0, 2, 32'hFFFF8001, 1'b0);
    txn("lhu22", 0, 1'b0, 32'h22, F3_HU, 32'h0, 2, 32'h00008001, 1'b0);
    txn("lb20",  0, 1'b0, 32'h20, F3_B,  32'h0, 2, 32'h0, 1'b0);

    // Errors
    txn("lw13",   0, 1'b0, 32'h13, F3_W,  32'h0, 2, 32'h0, 1'b1);
    txn("sw30",   0, 1'b1, 32'h30, F3_W,  32'hA5A5A5A5, 2, 32'h0, 1'b0);
    txn("sh31",   0, 1'b1, 32'h31, F3_H,  32'hFFFF, 2, 32'h0, 1'b1);
    txn("sbu30",  0, 1'b1, 32'h30, F3_BU, 32'hFFFF, 2, 32'h0, 1'b1);
    txn("lw30",   0, 1'b0, 32'h30, F3_W,  32'h0, 2, 32'hA5A5A5A5, 1'b0);
    txn("ld011",  0, 1'b0, 32'h30, 3'b011, 32'h0, 2, 32'h0, 1'b1);

    // Backpressure: hold the response 5 cycles
    issue(0, 1'b0, 32'h10, F3_W, 32'h0, n);
    chk("bp.lat", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.rdata", rsp_rdata[0], 32'hDEADBEEF);
      chk("bp.hold", {29'h0, rsp_err[0], rsp_valid[0], req_ready[0]}, 32'h2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp.release", {30'h0, rsp_valid[0], req_ready[0]}, 32'h1);

    // Wrap modulo 2^(AW+2)
    txn("sw000", 0, 1'b1, 32'h000, F3_W, 32'h0BADCAFE, 2, 32'h0, 1'b0);
    txn("lw400", 0, 1'b0, 32'h400, F3_W, 32'h0, 2, 32'h0BADCAFE, 1'b0);
    txn("lw000", 0, 1'b0, 32'h000, F3_W, 32'h0, 2, 32'h0BADCAFE, 1'b0);

    // LAT=1
    txn("l1.sw", 2, 1'b1, 32'h8, F3_W, 32'h55AA1234, 1, 32'h0, 1'b0);
    txn("l1.lw", 2, 1'b0, 32'h8, F3_W, 32'h0, 1, 32'h55AA1234, 1'b0);
    txn("l1.lh", 2, 1'b0, 32'h8, F3_H, 32'h0, 1, 32'h00001234, 1'b0);
    txn("l1.lb", 2, 1'b0, 32'hB, F3_B, 32'h0, 1, 32'h00000055, 1'b0);

    // Reset during BUSY on LAT=3 aborts an uncommitted store
    txn("l3.sw", 1, 1'b1, 32'h40, F3_W, 32'hCAFEF00D, 3, 32'h0, 1'b0);
    txn("l3.lw", 1, 1'b0, 32'h40, F3_W, 32'h0, 3, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h40; req_funct3 = F3_W; req_wdata = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("l3.busy", {30'h0, rsp_valid[1], req_ready[1]}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst2.ready", {31'h0, req_ready[1]}, 32'h1);
    chk("rst2.valid", {31'h0, rsp_valid[1]}, 32'h0);
    chk("rst2.rdata", rsp_rdata[1], 32'h0);
    chk("rst2.err",   {31'h0, rsp_err[1]}, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    txn("l3.lw2", 1, 1'b0, 32'h40, F3_W, 32'h0, 3, 32'hCAFEF00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
